onehot_encoder_pipe: RTL and testbench
======================================

// Module: onehot_encoder_pipe
// PURPOSE
//  Parametrised, registered N-to-log2(N) encoder with valid/ready handshake on both sides.
//  Run-time mode selects strict one-hot or MSB/LSB priority encoding.
//  Flags zero and multi-hot inputs, and keeps a saturating error counter.
//  Sits between request/select buses (arbiters, decoders) and index-consuming logic.
// PARAMETERS
//  N      8   input vector width; N >= 2, any value (not restricted to powers of 2)
//  W      $clog2(N)  output code width; localparam, not overridable
//  ERR_W  8   width of err_count
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  mode       in   2      0=strict one-hot, 1=priority MSB, 2=priority LSB, 3=reserved (treated as 0)
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can accept in_data this cycle
//  in_data    in   N      vector to encode
//  out_valid  out  1      out_* fields valid
//  out_ready  in   1      downstream accepts the result this cycle
//  out_code   out  W      encoded bit index
//  out_zero   out  1      accepted vector was all zeros
//  out_multi  out  1      accepted vector had more than one bit set
//  err_clr    in   1      synchronous clear of err_count
//  err_count  out  ERR_W  saturating count of erroneous accepted vectors
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, out_code=0, out_zero=0, out_multi=0, err_count=0.
//   in_ready=1 while rst is deasserted and the stage is empty.
//  Handshake:
//   - Input accept when in_valid && in_ready.
//   - Output transfer when out_valid && out_ready.
//   - in_ready = !out_valid || out_ready (combinational).
//   - Single register stage: latency 1 cycle, throughput 1 word/cycle.
//  On accept, out_* load from in_data and the mode sampled in the same cycle; out_valid <= 1.
//  If out_valid=1 and out_ready=0: out_* hold stable, in_ready=0. Producer holds in_data.
//  Transfer without accept: out_valid <= 0. Other out_* hold their values (don't care).
//  Encoding, k = index of set bit:
//   - Strict, exactly one bit set: out_code=k.
//   - Strict, zero or multi-hot: out_code=0.
//   - MSB mode: out_code = index of highest set bit.
//   - LSB mode: out_code = index of lowest set bit.
//   - in_data==0 in any mode: out_code=0, out_zero=1.
//   - out_multi = popcount(in_data) > 1 in every mode.
//  Error event (counted only on accept):
//   - strict mode: zero or multi-hot
//   - priority modes: zero only
//  err_count: +1 per error event, saturates at 2^ERR_W-1 (no wrap).
//   err_clr takes priority over an error event in the same cycle, giving err_count=0.
//   err_count is independent of out_ready stalls.
//  mode changes take effect on the next accepted word. A held output is not re-encoded.
//  rst asserted mid-transfer discards the held word immediately; no partial output.
// TESTING
//  T1 strict, N=8: in_data=1<<i for i=0..7 back-to-back, out_ready=1
//     -> out_code=i one cycle later; out_zero=0, out_multi=0; err_count stays 0.
//  T2 strict: 8'b0000_0011 -> code 0, multi=1, err_count=1.
//     8'h00 -> code 0, zero=1, err_count=2.
//  T3 MSB: 8'b1010_1010 -> code 7, multi=1.
//     LSB, same word -> code 1, multi=1; err_count unchanged.
//  T4 backpressure: accept 8'h10, hold out_ready=0 for 3 cycles
//     -> out_code=4 stable, in_ready=0; in_data=8'h40 not taken.
//     Release -> code 4 transfers, then code 6 the next cycle.
//  T5 ERR_W=2: 5 strict 8'h00 words -> err_count 1,2,3,3,3.
//     err_clr with a simultaneous error -> 0.
//  T6 N=5 (non-power-of-2): 5'b10000 -> code 4.
//     rst pulse while out_valid=1 -> out_valid=0 the same cycle, err_count=0.

Source files
------------

// File: rtl/onehot_encoder_pipe.sv
// Registered N-to-log2(N) encoder with strict one-hot or MSB/LSB priority modes,
// valid/ready handshake on both sides and a saturating error counter.
module onehot_encoder_pipe #(
  parameter  int N     = 8,
  parameter  int ERR_W = 8,
  localparam int W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_code,
  output logic             out_zero,
  output logic             out_multi,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] MODE_MSB = 2'd1;
  localparam logic [1:0] MODE_LSB = 2'd2;

  logic             accept;
  logic             isZero;
  logic             isMulti;
  logic [W-1:0]     hiIdx;
  logic [W-1:0]     loIdx;
  logic [W-1:0]     code_d;
  logic             errEvent;

  logic             outValid_q;
  logic [W-1:0]     code_q;
  logic             zero_q;
  logic             multi_q;
  logic [ERR_W-1:0] errCount_q;
  logic [ERR_W-1:0] errCount_d;

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    hiIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_data[i]) hiIdx = W'(i);
    end
  end

  always_comb begin
    loIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_data[i]) loIdx = W'(i);
    end
  end

  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  assign isZero  = (in_data == '0);
  assign isMulti = |(in_data & (in_data - N'(1)));

  // Reserved mode 3 falls into the strict branch; an all-zero vector yields code 0 everywhere.
  always_comb begin
    code_d   = '0;
    errEvent = isZero || isMulti;
    case (mode)
      MODE_MSB: begin
        code_d   = hiIdx;
        errEvent = isZero;
      end
      MODE_LSB: begin
        code_d   = loIdx;
        errEvent = isZero;
      end
      default: begin
        if (!isZero && !isMulti) code_d = hiIdx;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      code_q     <= '0;
      zero_q     <= 1'b0;
      multi_q    <= 1'b0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      code_q     <= code_d;
      zero_q     <= isZero;
      multi_q    <= isMulti;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  // A clear wins over a same-cycle error; the counter sticks at all-ones.
  always_comb begin
    errCount_d = errCount_q;
    if (err_clr) begin
      errCount_d = '0;
    end else if (accept && errEvent && (errCount_q != '1)) begin
      errCount_d = errCount_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) errCount_q <= '0;
    else     errCount_q <= errCount_d;
  end

  assign out_valid = outValid_q;
  assign out_code  = code_q;
  assign out_zero  = zero_q;
  assign out_multi = multi_q;
  assign err_count = errCount_q;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench for onehot_encoder_pipe: an N=8 instance, an N=8 instance with a
// 2-bit error counter and an N=5 instance, all driven by shared handshake inputs.
module tb_onehot_encoder_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       inValid = 1'b0;
  logic       outReady = 1'b0;
  logic       errClr = 1'b0;
  logic [7:0] data8 = 8'h00;
  logic [4:0] data5 = 5'h00;

  logic       ready8, valid8, zero8, multi8;
  logic [2:0] code8;
  logic [7:0] err8;
  logic       readyS, validS, zeroS, multiS;
  logic [2:0] codeS;
  logic [1:0] err2;
  logic       ready5, valid5, zero5, multi5;
  logic [2:0] code5;
  logic [7:0] err5;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference state, updated once per clock edge from the rules of the encoder.
  bit mValid;
  int mCode8, mCode5;
  bit mZero8, mMulti8, mZero5, mMulti5;
  int mErr8, mErr2, mErr5;

  always #5 clk = ~clk;

  onehot_encoder_pipe #(.N(8), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_ready(ready8),
    .in_data(data8), .out_valid(valid8), .out_ready(outReady), .out_code(code8),
    .out_zero(zero8), .out_multi(multi8), .err_clr(errClr), .err_count(err8)
  );

  onehot_encoder_pipe #(.N(8), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_ready(readyS),
    .in_data(data8), .out_valid(validS), .out_ready(outReady), .out_code(codeS),
    .out_zero(zeroS), .out_multi(multiS), .err_clr(errClr), .err_count(err2)
  );

  onehot_encoder_pipe #(.N(5), .ERR_W(8)) u_n5 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_ready(ready5),
    .in_data(data5), .out_valid(valid5), .out_ready(outReady), .out_code(code5),
    .out_zero(zero5), .out_multi(multi5), .err_clr(errClr), .err_count(err5)
  );

  // Encoding computed by counting set bits and remembering the extreme positions.
  function automatic void refEncode(input logic [7:0] d, input int n, input logic [1:0] m,
                                    output int code, output bit zero, output bit multi,
                                    output bit err);
    int cnt = 0;
    int hi = 0;
    int lo = 0;
    for (int i = 0; i < n; i++) begin
      if (d[i]) begin
        if (cnt == 0) lo = i;
        hi = i;
        cnt++;
      end
    end
    zero  = (cnt == 0);
    multi = (cnt > 1);
    if (m == 2'd1)      code = hi;
    else if (m == 2'd2) code = lo;
    else                code = (cnt == 1) ? hi : 0;
    err = (m == 2'd1 || m == 2'd2) ? zero : (cnt != 1);
  endfunction

  task automatic modelReset();
    mValid = 0;
    mCode8 = 0; mZero8 = 0; mMulti8 = 0;
    mCode5 = 0; mZero5 = 0; mMulti5 = 0;
    mErr8 = 0; mErr2 = 0; mErr5 = 0;
  endtask

  // Advances one clock edge and updates the reference model; returns at posedge+1.
  task automatic tick();
    bit acc, z, m, e, z5, m5, e5;
    int c, c5;
    acc = inValid && (!mValid || outReady);
    refEncode(data8, 8, mode, c, z, m, e);
    refEncode({3'b000, data5}, 5, mode, c5, z5, m5, e5);
    @(posedge clk);
    if (errClr) begin
      mErr8 = 0; mErr2 = 0; mErr5 = 0;
    end else if (acc) begin
      if (e && mErr8 < 255) mErr8++;
      if (e && mErr2 < 3)   mErr2++;
      if (e5 && mErr5 < 255) mErr5++;
    end
    if (acc) begin
      mValid = 1;
      mCode8 = c;  mZero8 = z;  mMulti8 = m;
      mCode5 = c5; mZero5 = z5; mMulti5 = m5;
    end else if (outReady) begin
      mValid = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    nCompared++;
    if ({valid8, code8, zero8, multi8, err8} !== 13'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got v=%0b c=%0d z=%0b m=%0b e=%0d expected all 0",
               valid8, code8, zero8, multi8, err8);
    end
    rst = 1'b0;
    #1;
    nCompared++;
    if (ready8 !== 1'b1 || ready5 !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_in_ready: got %0b/%0b expected 1", ready8, ready5);
    end
  endtask

  task automatic test_strict_onehot();
    mode = 2'd0; outReady = 1'b1; inValid = 1'b1; errClr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data8 = 8'(1 << i);
      data5 = 5'(1 << (i % 5));
      tick();
      nCompared++;
      if (valid8 !== 1'b1 || code8 !== 3'(i) || zero8 !== 1'b0 || multi8 !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL onehot_code[%0d]: got v=%0b c=%0d z=%0b m=%0b expected v=1 c=%0d z=0 m=0",
                 i, valid8, code8, zero8, multi8, i);
      end
      nCompared++;
      if (err8 !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL onehot_err[%0d]: got %0d expected 0", i, err8);
      end
    end
  endtask

  task automatic test_strict_errors();
    data5 = 5'b00001;
    data8 = 8'b0000_0011;
    tick();
    nCompared++;
    if (code8 !== 3'd0 || multi8 !== 1'b1 || zero8 !== 1'b0 || err8 !== 8'd1) begin
      nMismatched++;
      $display("[TB] FAIL strict_multi: got c=%0d m=%0b z=%0b e=%0d expected c=0 m=1 z=0 e=1",
               code8, multi8, zero8, err8);
    end
    data8 = 8'h00;
    tick();
    nCompared++;
    if (code8 !== 3'd0 || zero8 !== 1'b1 || multi8 !== 1'b0 || err8 !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL strict_zero: got c=%0d z=%0b m=%0b e=%0d expected c=0 z=1 m=0 e=2",
               code8, zero8, multi8, err8);
    end
  endtask

  task automatic test_priority();
    mode = 2'd1; data8 = 8'b1010_1010;
    tick();
    nCompared++;
    if (code8 !== 3'd7 || multi8 !== 1'b1 || err8 !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL msb_code: got c=%0d m=%0b e=%0d expected c=7 m=1 e=2", code8, multi8, err8);
    end
    mode = 2'd2;
    tick();
    nCompared++;
    if (code8 !== 3'd1 || multi8 !== 1'b1 || err8 !== 8'd2) begin
      nMismatched++;
      $display("[TB] FAIL lsb_code: got c=%0d m=%0b e=%0d expected c=1 m=1 e=2", code8, multi8, err8);
    end
    inValid = 1'b0;
    tick();
    nCompared++;
    if (valid8 !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL drain_valid: got %0b expected 0", valid8);
    end
  endtask

  task automatic test_backpressure();
    mode = 2'd0; outReady = 1'b1; inValid = 1'b1; data8 = 8'h10;
    tick();
    outReady = 1'b0; data8 = 8'h40;
    for (int k = 0; k < 3; k++) begin
      #1;
      nCompared++;
      if (ready8 !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL stall_ready[%0d]: got %0b expected 0", k, ready8);
      end
      tick();
      nCompared++;
      if (valid8 !== 1'b1 || code8 !== 3'd4) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%0b c=%0d expected v=1 c=4", k, valid8, code8);
      end
    end
    outReady = 1'b1;
    #1;
    nCompared++;
    if (ready8 !== 1'b1 || code8 !== 3'd4) begin
      nMismatched++;
      $display("[TB] FAIL release: got r=%0b c=%0d expected r=1 c=4", ready8, code8);
    end
    tick();
    nCompared++;
    if (valid8 !== 1'b1 || code8 !== 3'd6) begin
      nMismatched++;
      $display("[TB] FAIL back_to_back: got v=%0b c=%0d expected v=1 c=6", valid8, code8);
    end
    inValid = 1'b0;
    tick();
    nCompared++;
    if (valid8 !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL bp_drain: got %0b expected 0", valid8);
    end
  endtask

  task automatic test_saturation();
    int expSat[5] = '{1, 2, 3, 3, 3};
    errClr = 1'b1; inValid = 1'b0;
    tick();
    errClr = 1'b0; mode = 2'd0; data8 = 8'h00; inValid = 1'b1; outReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      nCompared++;
      if (err2 !== 2'(expSat[k])) begin
        nMismatched++;
        $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", k, err2, expSat[k]);
      end
    end
    errClr = 1'b1;
    tick();
    nCompared++;
    if (err2 !== 2'd0 || err8 !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL clr_priority: got %0d/%0d expected 0/0", err2, err8);
    end
    errClr = 1'b0; inValid = 1'b0;
    tick();
  endtask

  task automatic test_n5_and_reset();
    mode = 2'd0; data5 = 5'b10000; data8 = 8'h05; inValid = 1'b1; outReady = 1'b1;
    tick();
    nCompared++;
    if (valid5 !== 1'b1 || code5 !== 3'd4 || zero5 !== 1'b0 || multi5 !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL n5_code: got v=%0b c=%0d z=%0b m=%0b expected v=1 c=4 z=0 m=0",
               valid5, code5, zero5, multi5);
    end
    outReady = 1'b0; inValid = 1'b0;
    tick();
    nCompared++;
    if (valid5 !== 1'b1 || valid8 !== 1'b1 || err8 === 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL pre_reset_state: got v5=%0b v8=%0b e8=%0d expected v5=1 v8=1 e8>0",
               valid5, valid8, err8);
    end
    rst = 1'b1;
    #1;
    modelReset();
    nCompared++;
    if (valid5 !== 1'b0 || valid8 !== 1'b0 || err8 !== 8'd0 || err5 !== 8'd0 || code5 !== 3'd0) begin
      nMismatched++;
      $display("[TB] FAIL async_reset: got v5=%0b v8=%0b e8=%0d e5=%0d c5=%0d expected all 0",
               valid5, valid8, err8, err5, code5);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      inValid  = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      errClr   = ($urandom_range(0, 31) == 0);
      r = $urandom_range(0, 3);
      if (r == 0)      data8 = 8'h00;
      else if (r == 1) data8 = 8'(1 << $urandom_range(0, 7));
      else             data8 = 8'($urandom);
      data5 = 5'($urandom);
      #1;
      nCompared++;
      if ({ready8, readyS, ready5} !== {3{~mValid | outReady}} ||
          {valid8, validS, valid5} !== {3{mValid}}) begin
        nMismatched++;
        $display("[TB] FAIL rand_hs[%0d]: got r=%b v=%b expected r=%0b v=%0b", cyc,
                 {ready8, readyS, ready5}, {valid8, validS, valid5}, ~mValid | outReady, mValid);
      end
      nCompared++;
      if (err8 !== 8'(mErr8) || err2 !== 2'(mErr2) || err5 !== 8'(mErr5)) begin
        nMismatched++;
        $display("[TB] FAIL rand_err[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", cyc,
                 err8, err2, err5, mErr8, mErr2, mErr5);
      end
      if (mValid) begin
        nCompared++;
        if (code8 !== 3'(mCode8) || zero8 !== mZero8 || multi8 !== mMulti8 ||
            codeS !== 3'(mCode8) || code5 !== 3'(mCode5) || zero5 !== mZero5 ||
            multi5 !== mMulti5) begin
          nMismatched++;
          $display("[TB] FAIL rand_data[%0d]: got c8=%0d z8=%0b m8=%0b c5=%0d z5=%0b m5=%0b expected c8=%0d z8=%0b m8=%0b c5=%0d z5=%0b m5=%0b",
                   cyc, code8, zero8, multi8, code5, zero5, multi5,
                   mCode8, mZero8, mMulti8, mCode5, mZero5, mMulti5);
        end
      end
      tick();
    end
  endtask

  initial begin
    $display("[TB] onehot_encoder_pipe bench start");
    modelReset();
    test_reset();
    test_strict_onehot();
    test_strict_errors();
    test_priority();
    test_backpressure();
    test_saturation();
    test_n5_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
